// File: rtl/bram_subbank_reader.sv
// bram_subbank_reader: streams len consecutive words out of a single-port
// subbank, starting at a base address and wrapping modulo BANK_DEPTH. The
// 1-cycle read latency is absorbed by a 4-entry FIFO that feeds the output
// stream.
//
// Handshake: a word transfers on the output stream in every cycle where
// m_valid & m_ready are both high at the rising edge. While m_valid=1 and
// m_ready=0, m_data and m_last hold stable. m_valid never depends on m_ready.
module bram_subbank_reader #(
  parameter int DATA_WIDTH = 24,
  parameter int ADDR_WIDTH = 32,
  parameter int BANK_DEPTH = 32,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [LEN_WIDTH-1:0]  start_len,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic                  mem_cs,
  output logic                  mem_re,
  output logic [ADDR_WIDTH-1:0] mem_raddr,
  input  logic [DATA_WIDTH-1:0] mem_dout,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  input  logic                  m_ready,
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [LEN_WIDTH-1:0]  issued_q, issued_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  issue, last_issue;

  // A read issued last cycle returns data this cycle; its last tag travels with it.
  logic                  rd_pend_q, last_pend_q;

  // FIFO entries hold {last, data}.
  logic [DATA_WIDTH:0]   fifo_mem [4];
  logic [1:0]            wptr_q, rptr_q;
  logic [2:0]            cnt_q, cnt_d;
  logic [DATA_WIDTH:0]   head;
  logic                  push, pop;
  logic [3:0]            inflight;

  assign head     = fifo_mem[rptr_q];
  assign push     = rd_pend_q;
  assign pop      = m_valid & m_ready;
  // Words already buffered plus the one still in the subbank pipeline.
  assign inflight = {1'b0, cnt_q} + {3'b000, rd_pend_q};

  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign err       = err_q;
  assign mem_re    = issue;
  assign mem_cs    = issue;
  assign mem_raddr = issue ? addr_q : '0;
  assign m_valid   = (cnt_q != 3'd0);
  assign m_data    = m_valid ? head[DATA_WIDTH-1:0] : '0;
  assign m_last    = m_valid ? head[DATA_WIDTH] : 1'b0;
  assign dbg_state = state_q;

  // Next-state logic: command decode, credit-limited read issue, drain to completion.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    len_d      = len_q;
    issued_d   = issued_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    issue      = 1'b0;
    last_issue = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (start_addr >= ADDR_WIDTH'(BANK_DEPTH)) begin
            err_d = 1'b1;
          end else if (start_len == '0) begin
            done_d = 1'b1;
          end else begin
            addr_d   = start_addr;
            len_d    = start_len;
            issued_d = '0;
            state_d  = S_READ;
          end
        end
      end
      S_READ: begin
        // At most 4 words may be buffered or in flight, so the FIFO cannot overflow.
        if (inflight <= 4'd3) begin
          issue      = 1'b1;
          last_issue = (issued_q == len_q - LEN_WIDTH'(1));
          issued_d   = issued_q + LEN_WIDTH'(1);
          addr_d     = (addr_q == ADDR_WIDTH'(BANK_DEPTH - 1)) ? '0 : addr_q + ADDR_WIDTH'(1);
          if (last_issue) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (pop && head[DATA_WIDTH]) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FIFO occupancy: a simultaneous push and pop leaves it unchanged.
  always_comb begin
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 3'd1;
      2'b01:   cnt_d = cnt_q - 3'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Control and pointer registers; reset aborts any transfer and flushes the FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      len_q       <= '0;
      issued_q    <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      rd_pend_q   <= 1'b0;
      last_pend_q <= 1'b0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      issued_q    <= issued_d;
      done_q      <= done_d;
      err_q       <= err_d;
      rd_pend_q   <= issue;
      last_pend_q <= last_issue;
      if (push) wptr_q <= wptr_q + 2'd1;
      if (pop)  rptr_q <= rptr_q + 2'd1;
      cnt_q       <= cnt_d;
    end
  end

  // FIFO storage captures the subbank word together with its last tag.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wptr_q] <= {last_pend_q, mem_dout};
  end

endmodule

// File: tb/tb_bram_subbank_reader.sv
// Directed bench for bram_subbank_reader with a behavioural subbank model.
module tb_bram_subbank_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] start_addr;
  logic [15:0] start_len;
  logic        busy, done, err, mem_cs, mem_re;
  logic [31:0] mem_raddr;
  logic [23:0] mem_dout;
  logic        m_valid, m_last, m_ready;
  logic [23:0] m_data;
  logic [1:0]  dbg_state;

  int n_cmp = 0;
  int n_err = 0;
  logic [24:0] exp_q[$];
  bit          mon_en = 1'b0;
  logic [23:0] mem [32];

  bram_subbank_reader dut (
    .clk(clk), .rst(rst), .start(start), .start_addr(start_addr),
    .start_len(start_len), .busy(busy), .done(done), .err(err),
    .mem_cs(mem_cs), .mem_re(mem_re), .mem_raddr(mem_raddr),
    .mem_dout(mem_dout), .m_valid(m_valid), .m_data(m_data),
    .m_last(m_last), .m_ready(m_ready), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // subbank model: 1-cycle read latency, mem[i] = i
  always @(posedge clk) begin
    if (mem_cs && mem_re) mem_dout <= mem[mem_raddr[4:0]];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  // scoreboard: every accepted output word is compared with the expected queue
  always @(negedge clk) begin
    if (mon_en && m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        check("extra_word", {7'd0, m_last, m_data}, 32'hFFFF_FFFF);
      end else begin
        check("stream_word", {7'd0, m_last, m_data}, {7'd0, exp_q.pop_front()});
      end
    end
  end

  // driver tasks
  task automatic do_start(input logic [31:0] a, input logic [15:0] l);
    @(posedge clk); #1;
    start = 1'b1; start_addr = a; start_len = l;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic push_exp(input int a, input int l);
    for (int i = 0; i < l; i++) begin
      exp_q.push_back({(i == l - 1) ? 1'b1 : 1'b0, 24'((a + i) % 32)});
    end
  endtask

  task automatic wait_done(input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check("done_seen", {31'd0, seen}, 32'd1);
    check("busy_at_done", {31'd0, busy}, 32'd0);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
    check({tag, "_err"}, {31'd0, err}, 32'd0);
    check({tag, "_mem_re"}, {31'd0, mem_re}, 32'd0);
    check({tag, "_mem_cs"}, {31'd0, mem_cs}, 32'd0);
    check({tag, "_raddr"}, mem_raddr, 32'd0);
    check({tag, "_m_valid"}, {31'd0, m_valid}, 32'd0);
    check({tag, "_m_data"}, {8'd0, m_data}, 32'd0);
    check({tag, "_m_last"}, {31'd0, m_last}, 32'd0);
  endtask

  initial begin
    int reads;
    logic [31:0] wrap_seq [4];
    wrap_seq[0] = 32'd30; wrap_seq[1] = 32'd31; wrap_seq[2] = 32'd0; wrap_seq[3] = 32'd1;
    for (int i = 0; i < 32; i++) mem[i] = 24'(i);
    rst = 1'b1; start = 1'b0; start_addr = '0; start_len = '0; m_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_quiet("reset");

    // addr=10 len=5, full-rate cycle-by-cycle timing
    do_start(32'd10, 16'd5);
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      check("t1_mem_re", {31'd0, mem_re}, (c <= 5) ? 32'd1 : 32'd0);
      if (c <= 5) check("t1_raddr", mem_raddr, 32'(9 + c));
      check("t1_m_valid", {31'd0, m_valid}, (c >= 3 && c <= 7) ? 32'd1 : 32'd0);
      if (c >= 3 && c <= 7) check("t1_m_data", {8'd0, m_data}, 32'(7 + c));
      check("t1_m_last", {31'd0, m_last}, (c == 7) ? 32'd1 : 32'd0);
      check("t1_done", {31'd0, done}, (c == 8) ? 32'd1 : 32'd0);
      check("t1_busy", {31'd0, busy}, (c <= 7) ? 32'd1 : 32'd0);
    end

    // wrap: addr=30 len=4
    mon_en = 1'b1;
    push_exp(30, 4);
    do_start(32'd30, 16'd4);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("t2_mem_re", {31'd0, mem_re}, 32'd1);
      check("t2_raddr", mem_raddr, wrap_seq[c]);
    end
    wait_done(20);
    check("t2_left", exp_q.size(), 32'd0);

    // backpressure: addr=0 len=8, m_ready low for 10 cycles
    m_ready = 1'b0;
    push_exp(0, 8);
    do_start(32'd0, 16'd8);
    reads = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (mem_re) reads++;
    end
    check("t3_reads", reads, 32'd4);
    check("t3_m_valid", {31'd0, m_valid}, 32'd1);
    check("t3_m_data", {8'd0, m_data}, 32'd0);
    @(posedge clk); #1 m_ready = 1'b1;
    wait_done(40);
    check("t3_left", exp_q.size(), 32'd0);

    // zero length
    do_start(32'd5, 16'd0);
    @(negedge clk);
    check("t4_done", {31'd0, done}, 32'd1);
    check("t4_busy", {31'd0, busy}, 32'd0);
    check("t4_mem_re", {31'd0, mem_re}, 32'd0);
    check("t4_m_valid", {31'd0, m_valid}, 32'd0);
    @(negedge clk);
    check("t4_done_gone", {31'd0, done}, 32'd0);
    check("t4_mem_re2", {31'd0, mem_re}, 32'd0);

    // reset in cycle N+4 of a len=20 transfer
    mon_en = 1'b0;
    do_start(32'd0, 16'd20);
    repeat (3) @(negedge clk);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check_quiet("t5_after_rst");
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("t5_no_done", {31'd0, done}, 32'd0);
      check("t5_no_re", {31'd0, mem_re}, 32'd0);
    end
    mon_en = 1'b1;
    push_exp(3, 3);
    do_start(32'd3, 16'd3);
    wait_done(20);
    check("t5_left", exp_q.size(), 32'd0);

    // start while busy is ignored
    push_exp(20, 6);
    do_start(32'd20, 16'd6);
    start = 1'b1; start_addr = 32'd0; start_len = 16'd2;
    @(posedge clk); #1 start = 1'b0;
    wait_done(30);
    check("t6_left", exp_q.size(), 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("t6_idle_re", {31'd0, mem_re}, 32'd0);
      check("t6_idle_valid", {31'd0, m_valid}, 32'd0);
    end

    // bad address
    do_start(32'd40, 16'd3);
    @(negedge clk);
    check("t7_err", {31'd0, err}, 32'd1);
    check("t7_busy", {31'd0, busy}, 32'd0);
    check("t7_mem_re", {31'd0, mem_re}, 32'd0);
    check("t7_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    check("t7_err_gone", {31'd0, err}, 32'd0);
    check("t7_mem_re2", {31'd0, mem_re}, 32'd0);
    check("t7_busy2", {31'd0, busy}, 32'd0);

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // global time limit
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
